// File: rtl/div_unit.sv
// div_unit: iterative radix-2 integer divider for DIV/DIVU/REM/REMU and
// their 32-bit (W) variants. One quotient bit is produced per cycle on the
// operand magnitudes, and the signs are applied when the last bit is formed.
// Only one op is in flight. Its result is held until claimed or killed.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   req_valid/req_ready   issue handshake (ready only while idle)
//   req_opid              op id of the request
//   req_funct             [0]=unsigned, [1]=remainder
//   req_word              32-bit variant
//   req_a, req_b          dividend and divisor
//   resp_opid             op id; the top bit is the response valid flag
//   resp_data             result, held stable while the response is valid
//   resp_claim            the arbiter took the response this cycle
//   kill                  flush the op in flight; beats claim and req
module div_unit #(
  parameter int XLEN  = 64,
  parameter int OPIDW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OPIDW-1:0] req_opid,
  input  logic [1:0]       req_funct,
  input  logic             req_word,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  output logic [OPIDW-1:0] resp_opid,
  output logic [XLEN-1:0]  resp_data,
  input  logic             resp_claim,
  input  logic             kill
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [OPIDW-1:0] VBIT = {1'b1, {(OPIDW-1){1'b0}}};
  localparam logic [XLEN-1:0]  MINV = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [OPIDW-1:0] opid_q;
  logic             rem_op, word_q, neg_q, neg_r;
  logic [XLEN-1:0]  rem_q, quo_q, dvs_q;
  logic [CW-1:0]    cnt;

  function automatic logic [XLEN-1:0] sx32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  // ---------------- request decode ----------------
  logic            sgn, a_neg, b_neg, b_zero, ovf;
  logic [31:0]     a_mag32, b_mag32;
  logic [XLEN-1:0] a_mag, b_mag, a_val, spec_data, quo_init;

  always_comb begin
    sgn     = ~req_funct[0];
    a_neg   = sgn & (req_word ? req_a[31] : req_a[XLEN-1]);
    b_neg   = sgn & (req_word ? req_b[31] : req_b[XLEN-1]);
    a_mag32 = a_neg ? (32'd0 - req_a[31:0]) : req_a[31:0];
    b_mag32 = b_neg ? (32'd0 - req_b[31:0]) : req_b[31:0];
    // A signed MIN has no positive twin; its two's-complement negation is
    // still the correct unsigned magnitude.
    a_mag   = req_word ? {{(XLEN-32){1'b0}}, a_mag32} : (a_neg ? -req_a : req_a);
    b_mag   = req_word ? {{(XLEN-32){1'b0}}, b_mag32} : (b_neg ? -req_b : req_b);
    // Word dividends are pre-aligned to the top so that the first shift
    // produces the first significant quotient bit.
    quo_init = req_word ? (a_mag << (XLEN-32)) : a_mag;
    a_val   = req_word ? sx32(req_a[31:0]) : req_a;
    b_zero  = req_word ? (req_b[31:0] == 32'd0) : (req_b == '0);
    ovf     = sgn & (req_word ? (req_a[31:0] == 32'h8000_0000 && req_b[31:0] == 32'hFFFF_FFFF)
                              : (req_a == MINV && req_b == '1));
    if (b_zero)
      spec_data = req_funct[1] ? a_val : '1;
    else
      spec_data = req_funct[1] ? '0 : (req_word ? sx32(32'h8000_0000) : MINV);
  end

  // ---------------- shift-subtract step ----------------
  // The partial remainder is always below the divisor, so the shifted
  // value fits in XLEN+1 bits and the top bit of the trial is the borrow.
  logic [XLEN:0]   shl, trial;
  logic            fits;
  logic [XLEN-1:0] rem_n, quo_n, q_s, r_s, sel, fin;

  always_comb begin
    shl   = {rem_q, quo_q[XLEN-1]};
    trial = shl - {1'b0, dvs_q};
    fits  = ~trial[XLEN];
    rem_n = fits ? trial[XLEN-1:0] : shl[XLEN-1:0];
    quo_n = {quo_q[XLEN-2:0], fits};
    q_s   = neg_q ? -quo_n : quo_n;
    r_s   = neg_r ? -rem_n : rem_n;
    sel   = rem_op ? r_s : q_s;
    fin   = word_q ? sx32(sel[31:0]) : sel;
  end

  assign req_ready = (state == IDLE);

  // ---------------- control ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      opid_q    <= '0;
      rem_op    <= 1'b0;
      word_q    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt       <= '0;
      resp_opid <= '0;
      resp_data <= '0;
    end else if (kill) begin
      state     <= IDLE;
      resp_opid <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            opid_q <= req_opid;
            rem_op <= req_funct[1];
            word_q <= req_word;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dvs_q  <= b_mag;
            quo_q  <= quo_init;
            rem_q  <= '0;
            cnt    <= req_word ? CW'(32) : CW'(XLEN);
            if (b_zero || ovf) begin
              state     <= DONE;
              resp_data <= spec_data;
              resp_opid <= req_opid | VBIT;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          cnt   <= cnt - CW'(1);
          // The last bit is formed and the signs are applied on the same edge.
          if (cnt == CW'(1)) begin
            state     <= DONE;
            resp_data <= fin;
            resp_opid <= opid_q | VBIT;
          end
        end
        DONE: begin
          if (resp_claim) begin
            state     <= IDLE;
            resp_opid <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          resp_opid <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed plus randomized checks of div_unit against a
// plain-arithmetic reference of the divide/remainder rules.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [15:0] req_opid;
  logic [1:0]  req_funct;
  logic        req_word;
  logic [63:0] req_a, req_b;
  logic [15:0] resp_opid;
  logic [63:0] resp_data;
  logic        resp_claim, kill;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  div_unit #(.XLEN(64), .OPIDW(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opid(req_opid),
    .req_funct(req_funct), .req_word(req_word), .req_a(req_a), .req_b(req_b),
    .resp_opid(resp_opid), .resp_data(resp_data),
    .resp_claim(resp_claim), .kill(kill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Operands as seen by the op: word ops extend their low halves.
  function automatic logic [63:0] ext(input logic u, input logic w, input logic [63:0] v);
    if (!w) return v;
    return u ? {32'd0, v[31:0]} : {{32{v[31]}}, v[31:0]};
  endfunction

  function automatic logic [63:0] ref_res(input logic [1:0] f, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [63:0] x, y, q, r, res;
    x = ext(f[0], w, a);
    y = ext(f[0], w, b);
    if (y == 64'd0) begin
      q = '1; r = x;
    end else if (!f[0] && !w && x == MIN64 && y == '1) begin
      q = MIN64; r = 64'd0;
    end else if (f[0]) begin
      q = x / y; r = x % y;
    end else begin
      q = $signed(x) / $signed(y); r = $signed(x) % $signed(y);
    end
    res = f[1] ? r : q;
    if (w) res = {{32{res[31]}}, res[31:0]};
    return res;
  endfunction

  function automatic int ref_lat(input logic [1:0] f, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic [63:0] x, y;
    x = ext(f[0], w, a);
    y = ext(f[0], w, b);
    if (y == 64'd0) return 0;
    if (!f[0] && y == '1 && x == (w ? 64'hFFFF_FFFF_8000_0000 : MIN64)) return 0;
    return w ? 32 : 64;
  endfunction

  task automatic run_op(input logic [1:0] f, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input int hold);
    logic [63:0] exp_d, d0;
    logic [15:0] id, o0;
    int exp_lat, n;
    exp_d   = ref_res(f, w, a, b);
    exp_lat = ref_lat(f, w, a, b);
    id      = 16'($urandom);
    req_opid = id; req_funct = f; req_word = w; req_a = a; req_b = b; req_valid = 1'b1;
    chk("ready_idle", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
    req_a = {$urandom, $urandom};
    req_b = {$urandom, $urandom};
    n = 0;
    while (resp_opid[15] !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("latency", 64'(n), 64'(exp_lat));
    chk("data", resp_data, exp_d);
    chk("opid", 64'(resp_opid), 64'({1'b1, id[14:0]}));
    chk("ready_done", 64'(req_ready), 64'd0);
    if (hold > 0) begin
      d0 = resp_data; o0 = resp_opid;
      req_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        step();
        chk("hold_data", resp_data, d0);
        chk("hold_opid", 64'(resp_opid), 64'(o0));
        chk("hold_ready", 64'(req_ready), 64'd0);
      end
      req_valid = 1'b0;
    end
    resp_claim = 1'b1;
    step();
    resp_claim = 1'b0;
    chk("claim_valid", 64'(resp_opid[15]), 64'd0);
    chk("claim_ready", 64'(req_ready), 64'd1);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return '1;
      2: return MIN64;
      3: return 64'($urandom_range(0, 100));
      4: return {$urandom, 32'h8000_0000};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_opid = '0; req_funct = '0; req_word = 1'b0;
    req_a = '0; req_b = '0; resp_claim = 1'b0; kill = 1'b0;
    #12;
    chk("rst_opid", 64'(resp_opid), 64'd0);
    chk("rst_data", resp_data, 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    step();
    rst = 1'b1;
    step();

    // Directed cases
    run_op(2'b01, 1'b0, 64'd100, 64'd7, 0);                        // DIVU
    run_op(2'b11, 1'b0, 64'd100, 64'd7, 0);                        // REMU
    run_op(2'b00, 1'b0, -64'sd7, 64'd2, 0);                        // DIV
    run_op(2'b10, 1'b0, -64'sd7, 64'd2, 0);                        // REM
    run_op(2'b00, 1'b1, 64'h1_FFFF_FFF9, 64'd2, 0);                // DIVW
    run_op(2'b00, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0, 0);        // DIV x/0
    run_op(2'b10, 1'b0, 64'd5, 64'd0, 0);                          // REM 5/0
    run_op(2'b00, 1'b0, MIN64, '1, 0);                             // overflow
    run_op(2'b10, 1'b0, MIN64, '1, 0);
    run_op(2'b00, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 0);          // DIVW overflow
    run_op(2'b01, 1'b0, 64'd1000, 64'd3, 10);                      // held response

    // Kill mid-CALC; a request in the kill cycle must be ignored.
    req_opid = 16'h0042; req_funct = 2'b01; req_word = 1'b0;
    req_a = 64'd999; req_b = 64'd10; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      resp_claim = (i == 5);
      step();
      chk("kill_pre_valid", 64'(resp_opid[15]), 64'd0);
    end
    resp_claim = 1'b0;
    kill = 1'b1; req_valid = 1'b1;
    step();
    kill = 1'b0; req_valid = 1'b0;
    chk("kill_valid", 64'(resp_opid[15]), 64'd0);
    chk("kill_ready", 64'(req_ready), 64'd1);
    for (int i = 0; i < 70; i++) step();
    chk("kill_never_valid", 64'(resp_opid[15]), 64'd0);
    chk("kill_req_ignored", 64'(req_ready), 64'd1);
    run_op(2'b00, 1'b0, -64'sd100, 64'd7, 0);

    // Reset mid-CALC
    req_opid = 16'h0077; req_funct = 2'b01; req_word = 1'b0;
    req_a = 64'd50; req_b = 64'd3; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b0;
    #1;
    chk("rst_mid_opid", 64'(resp_opid), 64'd0);
    chk("rst_mid_data", resp_data, 64'd0);
    chk("rst_mid_ready", 64'(req_ready), 64'd1);
    step();
    rst = 1'b1;
    step();
    run_op(2'b11, 1'b0, 64'd50, 64'd3, 0);

    // Randomized ops
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  f;
      logic        w;
      logic [63:0] a, b;
      f = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      a = pick();
      b = pick();
      run_op(f, w, a, b, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
